// File: rtl/job_seq_ctrl.sv
// job_seq_ctrl: runs one job at a time through the datapath's length, input and output methods.
// Define JOB_SEQ_WDOG_EN to add a stall watchdog that aborts a job after TIMEOUT idle cycles.
module job_seq_ctrl #(
    parameter int DW      = 8,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       job_len,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [DW-1:0]    src_data,
    input  logic             src_valid,
    output logic             src_ready,
    output logic [DW-1:0]    snk_data,
    output logic             snk_valid,
    input  logic             snk_ready,
    output logic [7:0]       len_value,
    output logic             len_en,
    input  logic             len_rdy,
    output logic [DW-1:0]    din_value,
    output logic             din_en,
    input  logic             din_rdy,
    input  logic [DW-1:0]    dout_value,
    output logic             dout_en,
    input  logic             dout_rdy,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] jobs_done,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PROG   = 3'd1,
        S_STREAM = 3'd2,
        S_DONE   = 3'd3,
        S_ABORT  = 3'd4
    } state_t;

    state_t           r_state;
    logic [7:0]       r_len_q;
    logic [7:0]       r_in_cnt;
    logic [7:0]       r_out_cnt;
    logic [CNT_W-1:0] r_jobs_done;

    logic w_stream;
    logic w_in_open;
    logic w_out_open;

    // Handshake: a transfer happens on a rising edge where an enable/valid and its
    // rdy/ready are both high; every enable is gated by its rdy, so it never leads it.
    assign w_stream   = (r_state == S_STREAM);
    assign w_in_open  = w_stream && (r_in_cnt < r_len_q);
    assign w_out_open = w_stream && (r_out_cnt < r_len_q);

    assign job_ready = (r_state == S_IDLE);
    assign len_value = r_len_q;
    assign len_en    = (r_state == S_PROG) && len_rdy;
    assign din_value = src_data;
    assign din_en    = w_in_open && src_valid && din_rdy;
    assign src_ready = din_en;
    assign snk_data  = dout_value;
    assign snk_valid = w_out_open && dout_rdy;
    assign dout_en   = snk_valid && snk_ready;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign jobs_done = r_jobs_done;
    assign dbg_state = r_state;

`ifdef JOB_SEQ_WDOG_EN
    localparam int WDW = $clog2(TIMEOUT + 1) + 1;

    logic [WDW-1:0] r_wdog;
    logic [WDW-1:0] w_wdog_nxt;
    logic           w_xfer;

    assign w_xfer     = len_en || din_en || dout_en;
    assign w_wdog_nxt = r_wdog + 1'b1;
    assign err        = (r_state == S_ABORT);
`else
    // Without the watchdog a stalled job simply waits; err is constantly 0.
    assign err = 1'b0 && (TIMEOUT > 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_len_q     <= '0;
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_jobs_done <= '0;
`ifdef JOB_SEQ_WDOG_EN
            r_wdog      <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (job_valid) begin
                        r_len_q <= job_len;
                        r_state <= (job_len != 8'd0) ? S_PROG : S_DONE;
                    end
                end
                S_PROG: begin
                    if (len_en) begin
                        r_in_cnt  <= '0;
                        r_out_cnt <= '0;
                        r_state   <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (din_en)
                        r_in_cnt <= r_in_cnt + 8'd1;
                    if (dout_en) begin
                        r_out_cnt <= r_out_cnt + 8'd1;
                        if ((r_out_cnt + 8'd1) == r_len_q)
                            r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_jobs_done <= r_jobs_done + 1'b1;
                    r_state     <= S_IDLE;
                end
                S_ABORT: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
`ifdef JOB_SEQ_WDOG_EN
            // Counts consecutive cycles without any method transfer while a job is active.
            if ((r_state == S_PROG) || (r_state == S_STREAM)) begin
                if (w_xfer) begin
                    r_wdog <= '0;
                end else begin
                    r_wdog <= w_wdog_nxt;
                    if (w_wdog_nxt == WDW'(TIMEOUT))
                        r_state <= S_ABORT;
                end
            end else begin
                r_wdog <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_job_seq_ctrl.sv
// Directed bench for job_seq_ctrl with a queue-based mock datapath and source/sink.
// Build with JOB_SEQ_WDOG_EN defined to exercise the watchdog abort path.
module tb_job_seq_ctrl;

    localparam int DW      = 8;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       job_len;
    logic             job_valid;
    logic             job_ready;
    logic [DW-1:0]    src_data;
    logic             src_valid;
    logic             src_ready;
    logic [DW-1:0]    snk_data;
    logic             snk_valid;
    logic             snk_ready;
    logic [7:0]       len_value;
    logic             len_en;
    logic             len_rdy;
    logic [DW-1:0]    din_value;
    logic             din_en;
    logic             din_rdy;
    logic [DW-1:0]    dout_value;
    logic             dout_en;
    logic             dout_rdy;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] jobs_done;
    logic [2:0]       dbg_state;

    job_seq_ctrl #(.DW(DW), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .job_len(job_len), .job_valid(job_valid), .job_ready(job_ready),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
        .len_value(len_value), .len_en(len_en), .len_rdy(len_rdy),
        .din_value(din_value), .din_en(din_en), .din_rdy(din_rdy),
        .dout_value(dout_value), .dout_en(dout_en), .dout_rdy(dout_rdy),
        .busy(busy), .done(done), .err(err), .jobs_done(jobs_done),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time %0t exceeded bound", $time);
        $fatal(1, "bench did not finish");
    end

    // ---------------- mock environment ----------------
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] dp_q[$];
    logic [DW-1:0] got_q[$];
    logic [DW-1:0] exp_q[$];
    logic          src_on;
    logic          dout_on;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int acc_cyc, first_len, first_din, last_dout, done_cyc, err_cyc;
    int n_len, n_din, n_dout, n_done, n_err, n_viol;
    logic [7:0] last_len;
    logic [CNT_W-1:0] exp_jobs;

    // Source and datapath mock drive their outputs shortly after the falling edge.
    always @(negedge clk) begin
        #1;
        src_valid  = src_on && (src_q.size() != 0);
        src_data   = src_valid ? src_q[0] : '0;
        dout_rdy   = dout_on && (dp_q.size() != 0);
        dout_value = dout_rdy ? dp_q[0] : '0;
    end

    // Monitor samples just before each rising edge, when all inputs are settled.
    always @(negedge clk) begin
        #4;
        cyc++;
        if (!rst) begin
            if (job_valid && job_ready) acc_cyc = cyc;
            if (len_en) begin
                n_len++;
                last_len = len_value;
                if (first_len < 0) first_len = cyc;
            end
            if (din_en) begin
                n_din++;
                dp_q.push_back(din_value);
                if (src_q.size() != 0) void'(src_q.pop_front());
                if (first_din < 0) first_din = cyc;
            end
            if (dout_en) begin
                n_dout++;
                got_q.push_back(snk_data);
                if (dp_q.size() != 0) void'(dp_q.pop_front());
                last_dout = cyc;
            end
            if (done) begin n_done++; done_cyc = cyc; end
            if (err)  begin n_err++;  err_cyc  = cyc; end
            if ((len_en && !len_rdy) || (din_en && !din_rdy) || (dout_en && !dout_rdy) ||
                (dout_en && !snk_ready) || (src_ready !== din_en))
                n_viol++;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        n_len = 0; n_din = 0; n_dout = 0; n_done = 0; n_err = 0; n_viol = 0;
        first_len = -1; first_din = -1; last_dout = -1; done_cyc = -1; err_cyc = -1;
        acc_cyc = -1;
        got_q.delete(); exp_q.delete(); src_q.delete(); dp_q.delete();
    endtask

    task automatic load(input logic [7:0] b);
        src_q.push_back(b);
        exp_q.push_back(b);
    endtask

    task automatic submit(input logic [7:0] len);
        @(negedge clk);
        job_len   = len;
        job_valid = 1'b1;
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int budget);
        int  d0 = n_done;
        int  e0 = n_err;
        bit  hit = 1'b0;
        for (int k = 0; k < budget && !hit; k++) begin
            @(negedge clk);
            if (n_done != d0 || n_err != e0) hit = 1'b1;
        end
        #2;
        chk(tag, hit, 1);
    endtask

    task automatic chk_data(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk(tag, got_q[i], exp_q[i]);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_len_en"}, len_en, 0);
        chk({tag, "_din_en"}, din_en, 0);
        chk({tag, "_dout_en"}, dout_en, 0);
        chk({tag, "_src_ready"}, src_ready, 0);
        chk({tag, "_snk_valid"}, snk_valid, 0);
        chk({tag, "_jobs_done"}, jobs_done, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit hit;
        bit seen255;
        rst = 1'b1; job_len = '0; job_valid = 1'b0; snk_ready = 1'b0;
        len_rdy = 1'b0; din_rdy = 1'b0; src_on = 1'b0; dout_on = 1'b0;
        src_valid = 1'b0; src_data = '0; dout_rdy = 1'b0; dout_value = '0;
        exp_jobs = '0;
        clr();

        // Reset state
        repeat (3) @(negedge clk);
        #2;
        chk_idle_outputs("rst_held");
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk_idle_outputs("rst_rel");
        chk("rst_job_ready", job_ready, 1);

        // Four-byte job, everything ready
        clr();
        len_rdy = 1'b1; din_rdy = 1'b1; src_on = 1'b1; dout_on = 1'b1; snk_ready = 1'b1;
        load(8'h11); load(8'h22); load(8'h33); load(8'h44);
        submit(8'd4);
        wait_end("t4_end", 40);
        exp_jobs = exp_jobs + 1'b1;
        chk("t4_len_en", n_len, 1);
        chk("t4_len_val", last_len, 4);
        chk("t4_din", n_din, 4);
        chk("t4_dout", n_dout, 4);
        chk("t4_done", n_done, 1);
        chk("t4_err", n_err, 0);
        chk("t4_jobs", jobs_done, exp_jobs);
        chk("t4_len_lat", first_len - acc_cyc, 1);
        chk("t4_din_lat", first_din - acc_cyc, 2);
        chk("t4_busy", busy, 0);
        chk("t4_viol", n_viol, 0);
        chk_data("t4_data");

        // Zero-length job
        clr();
        submit(8'd0);
        wait_end("t0_end", 10);
        exp_jobs = exp_jobs + 1'b1;
        chk("t0_done_lat", done_cyc - acc_cyc, 1);
        chk("t0_len_en", n_len, 0);
        chk("t0_din", n_din, 0);
        chk("t0_dout", n_dout, 0);
        chk("t0_done", n_done, 1);
        chk("t0_jobs", jobs_done, exp_jobs);

        // Three bytes, sink toggling, input method stalled for five cycles
        clr();
        din_rdy = 1'b0; snk_ready = 1'b1;
        load(8'hA1); load(8'hB2); load(8'hC3);
        submit(8'd3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            snk_ready = ~snk_ready;
        end
        din_rdy = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 60 && !hit; k++) begin
            @(negedge clk);
            snk_ready = ~snk_ready;
            if (n_done != 0) hit = 1'b1;
        end
        #2;
        chk("t3_end", hit, 1);
        exp_jobs = exp_jobs + 1'b1;
        chk("t3_din_lat", first_din - acc_cyc, 6);
        chk("t3_din", n_din, 3);
        chk("t3_dout", n_dout, 3);
        chk("t3_done_after_dout", done_cyc - last_dout, 1);
        chk("t3_jobs", jobs_done, exp_jobs);
        chk("t3_viol", n_viol, 0);
        chk_data("t3_data");
        snk_ready = 1'b1;

        // Maximum length job
        clr();
        for (int i = 0; i < 255; i++) load(8'($urandom_range(0, 255)));
        submit(8'd255);
        wait_end("t255_end", 800);
        exp_jobs = exp_jobs + 1'b1;
        chk("t255_len_val", last_len, 255);
        chk("t255_din", n_din, 255);
        chk("t255_dout", n_dout, 255);
        chk("t255_done", n_done, 1);
        chk("t255_jobs", jobs_done, exp_jobs);
        chk("t255_viol", n_viol, 0);
        chk_data("t255_data");

        // Reset in the middle of a five-byte job
        clr();
        for (int i = 0; i < 5; i++) load(8'(8'h50 + i));
        submit(8'd5);
        hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            @(negedge clk);
            if (n_dout >= 2) hit = 1'b1;
        end
        chk("rstmid_reach2", hit, 1);
        rst = 1'b1;
        #2;
        chk_idle_outputs("rstmid");
        exp_jobs = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        chk("rstmid_no_done", n_done, 0);
        chk("rstmid_no_err", n_err, 0);
        clr();
        load(8'h9C); load(8'h3E);
        submit(8'd2);
        wait_end("after_rst_end", 40);
        exp_jobs = exp_jobs + 1'b1;
        chk("after_rst_done", n_done, 1);
        chk("after_rst_jobs", jobs_done, exp_jobs);
        chk_data("after_rst_data");

        // Length method held not-ready
        clr();
        len_rdy = 1'b0;
        load(8'h77);
        submit(8'd1);
`ifdef JOB_SEQ_WDOG_EN
        wait_end("wdog_end", 40);
        chk("wdog_err", n_err, 1);
        chk("wdog_err_lat", err_cyc - acc_cyc, 9);
        chk("wdog_no_done", n_done, 0);
        chk("wdog_jobs", jobs_done, exp_jobs);
        chk("wdog_idle", job_ready, 1);
        src_q.delete();
        len_rdy = 1'b1;
`else
        repeat (20) @(negedge clk);
        #2;
        chk("nowdog_err", n_err, 0);
        chk("nowdog_hang", busy, 1);
        chk("nowdog_len_en", n_len, 0);
        len_rdy = 1'b1;
        wait_end("nowdog_end", 40);
        exp_jobs = exp_jobs + 1'b1;
        chk("nowdog_done", n_done, 1);
        chk("nowdog_jobs", jobs_done, exp_jobs);
        chk_data("nowdog_data");
`endif

        // 256 back-to-back one-byte jobs from a fresh reset
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clr();
        for (int i = 0; i < 256; i++) load(8'(i));
        job_len = 8'd1;
        job_valid = 1'b1;
        hit = 1'b0;
        seen255 = 1'b0;
        for (int k = 0; k < 3000 && !hit; k++) begin
            @(negedge clk);
            if (n_done >= 256) begin
                job_valid = 1'b0;
                hit = 1'b1;
            end else if (n_done == 255 && !seen255) begin
                seen255 = 1'b1;
                #2;
                chk("wrap_255", jobs_done, 255);
            end
        end
        job_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk("wrap_end", hit, 1);
        chk("wrap_done", n_done, 256);
        chk("wrap_jobs", jobs_done, 0);
        chk("wrap_viol", n_viol, 0);
        chk_data("wrap_data");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
